// File: rtl/adc_pkg.sv
// Shared constants and FSM encoding for the ADC capture-RAM reader and its helpers.
// No logic, so no latency of its own.
// No handshake of its own; it only names the word layout and the reader states.
package adc_pkg;

    localparam int SAMPLE_W       = 14;
    localparam int LANE_STRIDE    = 16;
    localparam int LANES_PER_WORD = 4;
    localparam int WORD_W         = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        WAIT   = 2'd2,
        UNPACK = 2'd3
    } state_t;

endpackage

// File: rtl/adc_rdunpack_if.sv
// Sample stream from the RAM reader to the DSP/DAC path.
// Wires only, so there is no latency.
// valid/ready: the master holds sample and lane stable until ready is seen.
interface adc_rdunpack_if;

    logic [adc_pkg::SAMPLE_W-1:0] sample;
    logic [1:0]                   lane;
    logic                         valid;
    logic                         ready;

    modport master (output sample, output lane, output valid, input ready);
    modport slave  (input sample, input lane, input valid, output ready);

endinterface

// File: rtl/adc_lane_mux.sv
// Selects one 14-bit sample out of a packed 64-bit ADC word. Bits 14-15 of each lane are dropped.
// Combinational, zero cycles.
// No handshake; the caller qualifies the result.
module adc_lane_mux
    import adc_pkg::*;
(
    input  logic [WORD_W-1:0]   word,
    input  logic [1:0]          lane,
    output logic [SAMPLE_W-1:0] sample
);

    // Each lane starts on a 16-bit boundary; only its low 14 bits carry the sample.
    always_comb begin
        sample = word[32'(lane) * LANE_STRIDE +: SAMPLE_W];
    end

endmodule

// File: rtl/adc_rdunpack.sv
// Reads each word the ADC writer has committed and streams it out as four 14-bit samples.
// First sample RD_LATENCY+2 cycles after the level leaves zero. A word costs RD_LATENCY+5 cycles at full rate.
// A stalled sample holds sample and lane; no new read is issued until lane 3 is accepted.
// Optional: ADC_RDUNPACK_OVERRUN_EN adds the sticky overrun flag and the read-pointer resync.
module adc_rdunpack
    import adc_pkg::*;
#(
    parameter int RD_LATENCY = 2,
    parameter int DEPTH      = 16384,
    parameter int AW         = 15
) (
    input  logic              i_50clk,
    input  logic              i_nreset,
    input  logic [AW-1:0]     i_wr_ptr,
    output logic [AW-1:0]     o_rdaddress,
    output logic              o_rden,
    input  logic [WORD_W-1:0] i_q,
    adc_rdunpack_if.master    smp,
    output logic [AW-1:0]     o_level,
    output logic              o_overrun,
    input  logic              i_clr_overrun
);

    localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY - 1);

    // Reject parameter sets the 2-bit latency counter or the level compare cannot represent.
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("adc_rdunpack: RD_LATENCY must be 1..4");
    end
    if (DEPTH < 1 || DEPTH > (2 ** AW)) begin : g_bad_depth
        $error("adc_rdunpack: DEPTH must be 1..2^AW");
    end

    state_t              state;
    state_t              state_nxt;
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       addr_q;
    logic [1:0]          cnt;
    logic [WORD_W-1:0]   word;
    logic [1:0]          lane;
    logic                ovr_hit;
    logic                ovr_set;
    logic                resync;
    logic                accept;

    assign o_level = i_wr_ptr - rd_ptr;
    assign accept  = (state == UNPACK) && smp.ready;

`ifdef ADC_RDUNPACK_OVERRUN_EN
    localparam logic [AW:0] DEPTH_CMP = (AW + 1)'(DEPTH);
    // Overrun when the writer is at least DEPTH words ahead, so unread words are already overwritten.
    always_comb begin
        ovr_hit = ({1'b0, o_level} >= DEPTH_CMP);
    end
`else
    // Without the level check the reader never declares an overrun.
    always_comb begin
        ovr_hit = 1'b0;
    end
`endif

    // Next-state decision. The level is only consulted in IDLE and at the lane-3 accept.
    always_comb begin
        state_nxt = state;
        ovr_set   = 1'b0;
        resync    = 1'b0;
        case (state)
            IDLE: begin
                if (ovr_hit) begin
                    ovr_set = 1'b1;
                    resync  = 1'b1;
                end else if (o_level != '0) begin
                    state_nxt = READ;
                end
            end
            READ: state_nxt = WAIT;
            WAIT: begin
                if (cnt == 2'd0) begin
                    state_nxt = UNPACK;
                end
            end
            UNPACK: begin
                if (accept && (lane == 2'd3)) begin
                    if (ovr_hit) begin
                        ovr_set   = 1'b1;
                        resync    = 1'b1;
                        state_nxt = IDLE;
                    end else if (o_level != '0) begin
                        state_nxt = READ;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_50clk or negedge i_nreset) begin
        if (!i_nreset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Read pointer, latency counter, word capture, lane index and the sticky overrun flag.
    always_ff @(posedge i_50clk or negedge i_nreset) begin
        if (!i_nreset) begin
            rd_ptr    <= '0;
            addr_q    <= '0;
            cnt       <= 2'd0;
            word      <= '0;
            lane      <= 2'd0;
            o_overrun <= 1'b0;
        end else begin
            if (resync) begin
                rd_ptr <= i_wr_ptr;
            end else if (state == READ) begin
                rd_ptr <= rd_ptr + 1'b1;
                addr_q <= rd_ptr;
            end

            if (state == READ) begin
                cnt <= CNT_INIT;
            end else if ((state == WAIT) && (cnt != 2'd0)) begin
                cnt <= cnt - 1'b1;
            end

            if ((state == WAIT) && (cnt == 2'd0)) begin
                word <= i_q;
                lane <= 2'd0;
            end else if (accept) begin
                lane <= lane + 1'b1;
            end

            // A set in the same cycle as a clear leaves the flag set.
            o_overrun <= ovr_set | (o_overrun & ~i_clr_overrun);
        end
    end

    // The address is presented with the strobe and held afterwards for the RAM's benefit.
    assign o_rden      = (state == READ);
    assign o_rdaddress = (state == READ) ? rd_ptr : addr_q;
    assign smp.valid   = (state == UNPACK);
    assign smp.lane    = lane;

    adc_lane_mux u_lane_mux (
        .word   (word),
        .lane   (lane),
        .sample (smp.sample)
    );

endmodule
